// File: rtl/sparc_ifu_thrcmpl_pkg.sv
// Shared definitions for the IFU thread-completion tracker: default
// geometry, category indices and the flat strobe-vector index helper.
package sparc_ifu_thrcmpl_pkg;

  // Default geometry
  localparam int NTHR_DEF  = 4;
  localparam int NCAT_DEF  = 3;
  localparam int TMO_W_DEF = 10;

  // Category indices; anything from 3 upward is a generic category
  localparam int CAT_IMISS = 0;
  localparam int CAT_OTHER = 1;
  localparam int CAT_STB   = 2;

  // Position of (category c, thread t) inside a flat NTHR*NCAT strobe vector
  function automatic int cat_bit(input int c, input int t, input int nthr);
    return c * nthr + t;
  endfunction

endpackage : sparc_ifu_thrcmpl_pkg

// File: rtl/sparc_ifu_thrcmpl_slice.sv
// One thread of the completion tracker: the per-category pending flops,
// the park watchdog counter and the sticky timeout flag.
module sparc_ifu_thrcmpl_slice
  import sparc_ifu_thrcmpl_pkg::*;
#(
  parameter int NCAT  = NCAT_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active_i,
  input  logic [NCAT-1:0]  set_i,
  input  logic [NCAT-1:0]  rdy_i,
  input  logic             kill_i,
  input  logic [TMO_W-1:0] tmo_limit_i,
  input  logic             tmo_clr_i,
  output logic             completion_o,
  output logic [NCAT-1:0]  pend_o,
  output logic             tmo_fire_o,
  output logic             tmo_err_o
);

  logic [NCAT-1:0]  pend_q, pend_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic any_pend_s;
  logic sat_s;
  logic lim_on_s;
  logic expired_s;
  logic fire_s;
  logic cmpl_s;
  logic cnt_clr_s;

  // Summary terms: is anything parked, is every parked category ready now,
  // and has the watchdog run out on a still-unsatisfied wait
  always_comb begin
    any_pend_s = |pend_q;
    sat_s      = &(rdy_i | ~pend_q);
    lim_on_s   = (tmo_limit_i != {TMO_W{1'b0}});
    expired_s  = (cnt_q >= tmo_limit_i);
    fire_s     = any_pend_s & active_i & ~kill_i & lim_on_s & expired_s & ~sat_s;
    cmpl_s     = active_i & ~kill_i & any_pend_s & (sat_s | fire_s);
  end

  // Pending-bit next state: kill/inactive drops everything, a new set beats
  // a same-cycle ready or forced completion, otherwise ready/fire clears
  always_comb begin
    pend_d = pend_q;
    for (int c = 0; c < NCAT; c++) begin
      if (kill_i || !active_i) begin
        pend_d[c] = 1'b0;
      end else if (set_i[c]) begin
        pend_d[c] = 1'b1;
      end else if (rdy_i[c] || fire_s) begin
        pend_d[c] = 1'b0;
      end else begin
        pend_d[c] = pend_q[c];
      end
    end
  end

  // Watchdog: counts parked cycles, restarts whenever the wait ends or the
  // watchdog is disabled; firing at cnt >= limit keeps it from wrapping
  always_comb begin
    cnt_clr_s = ~any_pend_s | cmpl_s | kill_i | ~active_i | ~lim_on_s;
    if (cnt_clr_s) begin
      cnt_d = {TMO_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky timeout flag: a fire in the same cycle as a clear keeps it set
  always_comb begin
    if (fire_s) begin
      err_d = 1'b1;
    end else if (tmo_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State registers, dropped immediately by the asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= {NCAT{1'b0}};
      cnt_q  <= {TMO_W{1'b0}};
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign completion_o = cmpl_s;
  assign tmo_fire_o   = fire_s;
  assign pend_o       = pend_q;
  assign tmo_err_o    = err_q;

endmodule : sparc_ifu_thrcmpl_slice

// File: rtl/sparc_ifu_thrcmpl_gen.sv
// IFU thread-completion tracker. Re-packs the category-major strobe vectors
// into per-thread groups and instantiates one independent slice per thread.
module sparc_ifu_thrcmpl_gen
  import sparc_ifu_thrcmpl_pkg::*;
#(
  parameter int NTHR  = NTHR_DEF,
  parameter int NCAT  = NCAT_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NTHR-1:0]      thr_active,
  input  logic [NTHR*NCAT-1:0] wait_set,
  input  logic [NTHR*NCAT-1:0] wait_rdy,
  input  logic [NTHR-1:0]      wait_kill,
  input  logic [TMO_W-1:0]     tmo_limit,
  input  logic [NTHR-1:0]      tmo_clr,
  output logic [NTHR-1:0]      completion,
  output logic [NTHR*NCAT-1:0] wait_pend,
  output logic [NTHR-1:0]      tmo_fire,
  output logic [NTHR-1:0]      tmo_err
);

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    logic [NCAT-1:0] set_s;
    logic [NCAT-1:0] rdy_s;
    logic [NCAT-1:0] pend_s;

    for (genvar c = 0; c < NCAT; c++) begin : g_cat
      assign set_s[c]                       = wait_set[cat_bit(c, t, NTHR)];
      assign rdy_s[c]                       = wait_rdy[cat_bit(c, t, NTHR)];
      assign wait_pend[cat_bit(c, t, NTHR)] = pend_s[c];
    end

    sparc_ifu_thrcmpl_slice #(
      .NCAT  (NCAT),
      .TMO_W (TMO_W)
    ) u_slice (
      .clk          (clk),
      .reset        (reset),
      .active_i     (thr_active[t]),
      .set_i        (set_s),
      .rdy_i        (rdy_s),
      .kill_i       (wait_kill[t]),
      .tmo_limit_i  (tmo_limit),
      .tmo_clr_i    (tmo_clr[t]),
      .completion_o (completion[t]),
      .pend_o       (pend_s),
      .tmo_fire_o   (tmo_fire[t]),
      .tmo_err_o    (tmo_err[t])
    );
  end

endmodule : sparc_ifu_thrcmpl_gen

// File: tb/tb_sparc_ifu_thrcmpl_gen.sv
// Bench for the thread-completion tracker: directed scenarios followed by
// randomized traffic, all checked against a per-thread behavioural model.
module tb_sparc_ifu_thrcmpl_gen;

  localparam int NTHR  = 4;
  localparam int NCAT  = 3;
  localparam int TMO_W = 10;
  localparam int NB    = NTHR * NCAT;

  logic             clk = 1'b0;
  logic             reset;
  logic [NTHR-1:0]  thr_active;
  logic [NB-1:0]    wait_set;
  logic [NB-1:0]    wait_rdy;
  logic [NTHR-1:0]  wait_kill;
  logic [TMO_W-1:0] tmo_limit;
  logic [NTHR-1:0]  tmo_clr;
  logic [NTHR-1:0]  completion;
  logic [NB-1:0]    wait_pend;
  logic [NTHR-1:0]  tmo_fire;
  logic [NTHR-1:0]  tmo_err;

  sparc_ifu_thrcmpl_gen #(.NTHR(NTHR), .NCAT(NCAT), .TMO_W(TMO_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .thr_active (thr_active),
    .wait_set   (wait_set),
    .wait_rdy   (wait_rdy),
    .wait_kill  (wait_kill),
    .tmo_limit  (tmo_limit),
    .tmo_clr    (tmo_clr),
    .completion (completion),
    .wait_pend  (wait_pend),
    .tmo_fire   (tmo_fire),
    .tmo_err    (tmo_err)
  );

  always #5 clk = ~clk;

  // Reference state: which categories each thread is parked on, how long it
  // has been parked, and whether it ever timed out
  bit m_pend [NCAT][NTHR];
  int m_cnt  [NTHR];
  bit m_err  [NTHR];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int t = 0; t < NTHR; t++) begin
      m_cnt[t] = 0;
      m_err[t] = 1'b0;
      for (int c = 0; c < NCAT; c++) m_pend[c][t] = 1'b0;
    end
  endtask

  task automatic drive_idle();
    wait_set  = '0;
    wait_rdy  = '0;
    wait_kill = '0;
    tmo_clr   = '0;
  endtask

  // Called at a falling edge with inputs applied: compares the DUT against
  // the model, advances the model across the rising edge, returns at the
  // next falling edge.
  task automatic step(input string tag);
    logic [NTHR-1:0] e_cmpl, e_fire, e_err;
    logic [NB-1:0]   e_pend;
    bit n_pend [NCAT][NTHR];
    int n_cnt  [NTHR];
    bit n_err  [NTHR];
    #1;
    e_cmpl = '0; e_fire = '0; e_err = '0; e_pend = '0;
    for (int t = 0; t < NTHR; t++) begin
      bit act, kill, waiting, all_ready, lim_on, timed_out, done;
      act       = thr_active[t];
      kill      = wait_kill[t];
      waiting   = 1'b0;
      all_ready = 1'b1;
      for (int c = 0; c < NCAT; c++) begin
        e_pend[c*NTHR+t] = m_pend[c][t];
        if (m_pend[c][t]) begin
          waiting = 1'b1;
          if (!wait_rdy[c*NTHR+t]) all_ready = 1'b0;
        end
      end
      lim_on    = (int'(tmo_limit) != 0);
      timed_out = waiting && act && !kill && lim_on &&
                  (m_cnt[t] >= int'(tmo_limit)) && !all_ready;
      done      = act && !kill && waiting && (all_ready || timed_out);
      e_cmpl[t] = done;
      e_fire[t] = timed_out;
      e_err[t]  = m_err[t];
      for (int c = 0; c < NCAT; c++) begin
        if (kill || !act)                        n_pend[c][t] = 1'b0;
        else if (wait_set[c*NTHR+t])             n_pend[c][t] = 1'b1;
        else if (wait_rdy[c*NTHR+t] || timed_out) n_pend[c][t] = 1'b0;
        else                                      n_pend[c][t] = m_pend[c][t];
      end
      if (!waiting || done || kill || !act || !lim_on) n_cnt[t] = 0;
      else                                             n_cnt[t] = m_cnt[t] + 1;
      if (timed_out)      n_err[t] = 1'b1;
      else if (tmo_clr[t]) n_err[t] = 1'b0;
      else                 n_err[t] = m_err[t];
    end
    check_eq({tag, ".completion"}, 64'(completion), 64'(e_cmpl));
    check_eq({tag, ".tmo_fire"},   64'(tmo_fire),   64'(e_fire));
    check_eq({tag, ".wait_pend"},  64'(wait_pend),  64'(e_pend));
    check_eq({tag, ".tmo_err"},    64'(tmo_err),    64'(e_err));
    @(posedge clk);
    m_pend = n_pend;
    m_cnt  = n_cnt;
    m_err  = n_err;
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    thr_active = '1;
    tmo_limit  = '0;
    drive_idle();
    model_clear();
    #2;
    check_eq("reset.completion", 64'(completion), 64'd0);
    check_eq("reset.wait_pend",  64'(wait_pend),  64'd0);
    check_eq("reset.tmo_fire",   64'(tmo_fire),   64'd0);
    check_eq("reset.tmo_err",    64'(tmo_err),    64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Partial then final ready on thread 1, watchdog off
    for (int k = 0; k < 12; k++) begin
      drive_idle();
      if (k == 0) begin wait_set[0*NTHR+1] = 1'b1; wait_set[1*NTHR+1] = 1'b1; end
      if (k == 5) wait_rdy[0*NTHR+1] = 1'b1;
      if (k == 9) wait_rdy[1*NTHR+1] = 1'b1;
      #1 check_eq("partial.cmpl", 64'(completion), (k == 9) ? 64'h2 : 64'h0);
      step("partial");
    end

    // Set and ready colliding on a non-pending bit of thread 2
    for (int k = 0; k < 6; k++) begin
      drive_idle();
      if (k == 0) begin wait_set[1*NTHR+2] = 1'b1; wait_rdy[1*NTHR+2] = 1'b1; end
      if (k == 3) wait_rdy[1*NTHR+2] = 1'b1;
      #1 check_eq("collide.cmpl", 64'(completion), (k == 3) ? 64'h4 : 64'h0);
      if (k == 1) check_eq("collide.pend", 64'(wait_pend[1*NTHR+2]), 64'd1);
      step("collide");
    end

    // Kill, then thread deactivation, on a pending stb wait of thread 0
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 5; k++) begin
        drive_idle();
        thr_active = '1;
        if (k == 0) wait_set[2*NTHR+0] = 1'b1;
        if (k == 2) begin
          wait_rdy[2*NTHR+0] = 1'b1;
          if (pass == 0) wait_kill[0] = 1'b1;
          else           thr_active[0] = 1'b0;
        end
        #1 check_eq("kill.cmpl", 64'(completion), 64'h0);
        if (k == 3) check_eq("kill.pend", 64'(wait_pend[2*NTHR+0]), 64'd0);
        step("kill");
      end
    end
    thr_active = '1;

    // Watchdog on thread 3 with limit 8, then fire colliding with a clear
    tmo_limit = 10'd8;
    for (int k = 0; k < 25; k++) begin
      drive_idle();
      if (k == 0 || k == 13) wait_set[1*NTHR+3] = 1'b1;
      if (k == 12 || k == 22) tmo_clr[3] = 1'b1;
      #1 check_eq("wdog.fire", 64'(tmo_fire), (k == 9 || k == 22) ? 64'h8 : 64'h0);
      check_eq("wdog.cmpl", 64'(completion), (k == 9 || k == 22) ? 64'h8 : 64'h0);
      if (k == 11) check_eq("wdog.err_set", 64'(tmo_err), 64'h8);
      if (k == 13) check_eq("wdog.err_clr", 64'(tmo_err), 64'h0);
      if (k == 23) check_eq("wdog.err_win", 64'(tmo_err), 64'h8);
      step("wdog");
    end

    // All threads complete together
    tmo_limit = 10'd0;
    for (int k = 0; k < 5; k++) begin
      drive_idle();
      if (k == 0) wait_set[2*NTHR +: NTHR] = '1;
      if (k == 3) wait_rdy[2*NTHR +: NTHR] = '1;
      #1 check_eq("all.cmpl", 64'(completion), (k == 3) ? 64'hF : 64'h0);
      step("all");
    end

    // Asynchronous reset mid-wait with the watchdog counter at 5
    tmo_limit = 10'd20;
    for (int k = 0; k < 6; k++) begin
      drive_idle();
      if (k == 0) begin wait_set[0*NTHR+0] = 1'b1; wait_set[1*NTHR+2] = 1'b1; end
      step("prereset");
    end
    drive_idle();
    reset = 1'b1;
    #1;
    check_eq("areset.wait_pend",  64'(wait_pend),  64'd0);
    check_eq("areset.tmo_err",    64'(tmo_err),    64'd0);
    check_eq("areset.completion", 64'(completion), 64'd0);
    check_eq("areset.tmo_fire",   64'(tmo_fire),   64'd0);
    model_clear();
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Counter must restart from 0 after the reset: fire lands on the 21st parked cycle
    for (int k = 0; k < 24; k++) begin
      drive_idle();
      if (k == 0) wait_set[1*NTHR+1] = 1'b1;
      step("postreset");
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ((n % 60) == 0) tmo_limit = TMO_W'($urandom_range(0, 12));
      for (int t = 0; t < NTHR; t++) begin
        thr_active[t] = ($urandom_range(0, 15) != 0);
        wait_kill[t]  = ($urandom_range(0, 31) == 0);
        tmo_clr[t]    = ($urandom_range(0, 15) == 0);
      end
      for (int b = 0; b < NB; b++) begin
        wait_set[b] = ($urandom_range(0, 7) == 0);
        wait_rdy[b] = ($urandom_range(0, 5) == 0);
      end
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sparc_ifu_thrcmpl_gen

// File: doc/sparc_ifu_thrcmpl_gen.md
Name: sparc_ifu_thrcmpl_gen

Overview:
Parametrised thread-completion tracker for the IFU.
- Holds per-thread, per-category wait-pending state (imiss, other, stb-wait, and further categories by parameter).
- Merges per-category ready strobes into one completion pulse per thread.
- Adds a per-thread watchdog. If a thread stays parked past a programmable limit, the watchdog forces completion and records a sticky error.
- Sits between the fetch-control thread scheduler and the LSU/EXU/FFU/IFQ completion sources.

Parameters:
NTHR, 4, number of hardware threads.
NCAT, 3, number of wait categories (0 = imiss, 1 = other, 2 = stb-wait; categories at index 3 and above are generic).
TMO_W, 10, width of the watchdog counter and of the limit field.

Ports:
clk  in  1  core clock.
reset  in  1  asynchronous, active-high reset.
thr_active  in  NTHR  thread-enabled mask.
wait_set  in  NTHR*NCAT  set strobes; bit index c*NTHR+t.
wait_rdy  in  NTHR*NCAT  ready/clear strobes; same indexing.
wait_kill  in  NTHR  drop all waits for the thread, no completion (flush/retract).
tmo_limit  in  TMO_W  watchdog limit; 0 disables the watchdog.
tmo_clr  in  NTHR  clear sticky timeout error.
completion  out  NTHR  thread-ready pulse (combinational from state and inputs).
wait_pend  out  NTHR*NCAT  registered pending bits.
tmo_fire  out  NTHR  one-cycle forced-completion indication (combinational).
tmo_err  out  NTHR  sticky timeout flag (registered).

Behaviour:
- Reset: wait_pend=0, watchdog counters=0, tmo_err=0. Consequently completion=0 and tmo_fire=0.
- Per-thread terms:
  - any_pend[t] = OR over c of pend[c][t].
  - sat[t] = AND over c of (rdy[c][t] | ~pend[c][t]).
- completion[t] = thr_active[t] & ~wait_kill[t] & any_pend[t] & (sat[t] | tmo_fire[t]).
  - Zero-latency: completion is asserted in the same cycle as the final ready.
  - Categories clear independently. A partial ready clears its own bit with no completion.
- pend[c][t] next-state, in priority order:
  1. reset -> 0.
  2. wait_kill[t] or ~thr_active[t] -> 0.
  3. wait_set[c][t] -> 1 (a set wins over a simultaneous rdy or tmo_fire).
  4. rdy[c][t] or tmo_fire[t] -> 0.
  5. Otherwise hold.
- A set and a rdy in the same cycle on a non-pending bit: the bit is pending next cycle and no completion occurs. Completion only evaluates registered pend bits.
- Watchdog cnt[t]:
  - Clears to 0 when any of these holds: ~any_pend[t], completion[t], wait_kill[t], ~thr_active[t], or tmo_limit==0.
  - Otherwise increments by 1.
  - Never wraps: cnt >= tmo_limit fires before the counter can overflow.
- tmo_fire[t] = any_pend[t] & thr_active[t] & ~wait_kill[t] & (tmo_limit!=0) & (cnt[t] >= tmo_limit) & ~sat[t].
  - Use >= so that lowering tmo_limit mid-wait fires on the next evaluation.
  - On fire: completion pulses, every pend bit for the thread clears (unless re-set that cycle), and the counter returns to 0.
- tmo_err[t]:
  - Set on tmo_fire[t].
  - Cleared by tmo_clr[t].
  - Set wins over a simultaneous clear.
- Threads are fully independent. Any mix of threads may complete in the same cycle.
- Asserting reset mid-wait drops all state immediately, asynchronously.

Decomposition:
- Shared package sparc_ifu_thrcmpl_pkg holds:
  - Category index constants: CAT_IMISS=0, CAT_OTHER=1, CAT_STB=2.
  - Default NTHR/NCAT/TMO_W.
  - An index function cat_bit(c,t) = c*NTHR+t.
- Natural sub-module: sparc_ifu_thrcmpl_slice.
  - One thread: NCAT pending flops, the watchdog counter, and tmo_err.
  - Instantiated NTHR times by a generate loop.
  - The top level does only bit re-packing.

Test Plan:
- Partial then final ready, tmo_limit=0. Set imiss and other on t1; rdy imiss at cycle 5; rdy other at cycle 9. Required: completion=4'b0010 only at cycle 9; wait_pend for t1 is 0 from cycle 10.
- Set/rdy collision. Set other[t2] and rdy other[t2] in the same cycle with nothing pending. Required: no completion; pend[other][t2]=1 next cycle; a later rdy gives a one-cycle completion.
- Kill and inactive. Pend stb on t0, then wait_kill[0]=1. Required: completion stays 0 and pend clears. Repeat with thr_active[0] dropped: same result.
- Watchdog. tmo_limit=8; set other on t3 and withhold rdy. Required: tmo_fire[3] and completion[3] at the 9th pending cycle (cnt==8); pend cleared; tmo_err[3]=1 until tmo_clr; set and tmo_clr together leaves tmo_err=1.
- All threads simultaneously. NTHR=8, NCAT=4 build. All threads have cat3 pending; assert all rdy together. Required: completion=8'hFF for one cycle.
- Asynchronous reset mid-wait. Assert reset between clock edges with waits pending and cnt=5. Required: wait_pend, tmo_err and counters go to 0 immediately, and completion=0.
